mux_stream_rr: RTL and testbench

//  N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshake on every port.

---
 rtl/mux_stream_rr.sv | 112 +++++++++++
 tb/tb_mux_stream_rr.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_stream_rr.sv
// N-channel registered stream multiplexer with valid/ready on every port.
// Static-select or round-robin grant feeds a single output register stage.
module mux_stream_rr #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [SEL_W-1:0]  gnt;
  logic              gnt_vld;
  logic [WIDTH-1:0]  gnt_data;
  logic              load_en;
  logic              xfer;
  logic              found;
  int unsigned       idx;

  // Round-robin search begins just past the last granted channel.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    found   = 1'b0;
    idx     = 0;
    if (!mode) begin
      gnt = sel;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (SEL_W'(i) == sel) gnt_vld = in_valid[i];
      end
    end else begin
      for (int unsigned k = 1; k <= N_CH; k++) begin
        idx = (32'(rr_ptr_q) + k) % N_CH;
        if (!found && in_valid[idx]) begin
          found = 1'b1;
          gnt   = SEL_W'(idx);
        end
      end
      gnt_vld = found;
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (SEL_W'(i) == gnt) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign load_en = (state_q == ST_EMPTY) | out_ready;
  assign xfer    = load_en & gnt_vld;

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      in_ready[i] = xfer & (SEL_W'(i) == gnt);
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    ch_d     = ch_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      state_d  = ST_FULL;
      data_d   = gnt_data;
      ch_d     = gnt;
      rr_ptr_d = gnt;
    end else if (out_ready) begin
      state_d  = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      data_q   <= '0;
      ch_q     <= '0;
      rr_ptr_q <= SEL_W'(N_CH - 1);
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      ch_q     <= ch_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Bench for mux_stream_rr: per-scenario tasks with inline checks, plus a
// scoreboard that tracks every accepted word through to the consumer.
module tb_mux_stream_rr;

  logic        clk;
  logic        rst;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;

  int errors = 0;
  int checks = 0;
  logic [17:0] sb_q[$];

  localparam logic [63:0] DATA_DEF = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};

  mux_stream_rr #(.N_CH(4), .WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer-side scoreboard: pop the delivered word, then record new accepts.
  always @(negedge clk) begin
    if (!rst) begin
      logic [17:0] exp_w;
      checks++;
      if ($countones(in_ready) > 1) begin
        errors++;
        $display("FAIL ready_onehot: in_ready=%b required at most one bit set", in_ready);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got ch=%0d data=%h, required no output word", out_ch, out_data);
        end else begin
          exp_w = sb_q.pop_front();
          if ({out_ch, out_data} !== exp_w) begin
            errors++;
            $display("FAIL sb_word: got ch=%0d data=%h, required ch=%0d data=%h",
                     out_ch, out_data, exp_w[17:16], exp_w[15:0]);
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i] && in_ready[i]) sb_q.push_back({2'(i), in_data[i*16 +: 16]});
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_data   = DATA_DEF;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '0; out_ready = 1'b0; mode = 1'b0; sel = '0; in_data = DATA_DEF;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", out_valid); end
    if (out_data !== 16'h0) begin errors++; $display("FAIL rst_data: got %h required 0000", out_data); end
    if (out_ch !== 2'd0) begin errors++; $display("FAIL rst_ch: got %0d required 0", out_ch); end
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b required 0000", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_static_sel();
    do_reset();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    checks += 2;
    if (in_ready !== 4'b0100) begin errors++; $display("FAIL sel_ready0: got %b required 0100", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL sel_valid0: got %b required 0", out_valid); end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL sel_valid[%0d]: got %b required 1", k, out_valid); end
      if (out_data !== 16'h9ABC) begin errors++; $display("FAIL sel_data[%0d]: got %h required 9abc", k, out_data); end
      if (out_ch !== 2'd2) begin errors++; $display("FAIL sel_ch[%0d]: got %0d required 2", k, out_ch); end
      if (in_ready !== 4'b0100) begin errors++; $display("FAIL sel_ready[%0d]: got %b required 0100", k, in_ready); end
    end
    in_valid = 4'b1011;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL sel_drop_ready: got %b required 0000", in_ready); end
    @(posedge clk); #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL sel_drop_valid: got %b required 0", out_valid); end
    if (out_data !== 16'h9ABC) begin errors++; $display("FAIL sel_drop_hold: got %h required 9abc", out_data); end
  endtask

  task automatic test_rr_all();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL rr_ready0: got %b required 0001", in_ready); end
    for (int k = 0; k < 6; k++) begin
      logic [1:0] exp_ch, nxt;
      logic [3:0] exp_rdy;
      exp_ch  = 2'(k % 4);
      nxt     = 2'((k + 1) % 4);
      exp_rdy = 4'b0001 << nxt;
      @(posedge clk); #1;
      checks += 3;
      if (out_ch !== exp_ch) begin errors++; $display("FAIL rr_ch[%0d]: got %0d required %0d", k, out_ch, exp_ch); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b required 1", k, out_valid); end
      if (in_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d]: got %b required %b", k, in_ready, exp_rdy); end
    end
  endtask

  task automatic test_rr_sparse();
    do_reset();
    mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_ch;
      exp_ch = (k % 2 == 0) ? 2'd1 : 2'd3;
      @(posedge clk); #1;
      checks += 2;
      if (out_ch !== exp_ch) begin errors++; $display("FAIL sparse_ch[%0d]: got %0d required %0d", k, out_ch, exp_ch); end
      if ((in_ready & 4'b0101) !== 4'b0000) begin errors++; $display("FAIL sparse_ready[%0d]: got %b required ch0/ch2 low", k, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_data[16 +: 16] = 16'h1111;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready0: got %b required 0000", in_ready); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b required 1", k, out_valid); end
      if (out_ch !== 2'd1) begin errors++; $display("FAIL bp_ch[%0d]: got %0d required 1", k, out_ch); end
      if (out_data !== 16'h5678) begin errors++; $display("FAIL bp_data[%0d]: got %h required 5678", k, out_data); end
      if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b required 0000", k, in_ready); end
    end
    in_data = DATA_DEF;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_rel_ready: got %b required 0100", in_ready); end
    @(posedge clk); #1;
    checks += 2;
    if (out_ch !== 2'd2) begin errors++; $display("FAIL bp_rel_ch: got %0d required 2", out_ch); end
    if (out_data !== 16'h9ABC) begin errors++; $display("FAIL bp_rel_data: got %h required 9abc", out_data); end
    @(posedge clk); #1;
    checks++;
    if (out_ch !== 2'd3) begin errors++; $display("FAIL bp_rel_ch2: got %0d required 3", out_ch); end
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mode = 1'b0; sel = 2'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    checks += 2;
    if (out_ch !== 2'd1) begin errors++; $display("FAIL ms_hold_ch: got %0d required 1", out_ch); end
    if (out_data !== 16'h5678) begin errors++; $display("FAIL ms_hold_data: got %h required 5678", out_data); end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL ms_ready: got %b required 0001", in_ready); end
    @(posedge clk); #1;
    checks += 2;
    if (out_ch !== 2'd0) begin errors++; $display("FAIL ms_ch: got %0d required 0", out_ch); end
    if (out_data !== 16'h1234) begin errors++; $display("FAIL ms_data: got %h required 1234", out_data); end
    mode = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin errors++; $display("FAIL ms_rr_ready: got %b required 0010", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_ch !== 2'd1) begin errors++; $display("FAIL ms_rr_ch: got %0d required 1", out_ch); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mr_pre_valid: got %b required 1", out_valid); end
    #2;
    rst = 1'b1;
    sb_q.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_async_valid: got %b required 0", out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL mr_ready: got %b required 0001", in_ready); end
    @(posedge clk); #1;
    checks += 2;
    if (out_ch !== 2'd0) begin errors++; $display("FAIL mr_ch: got %0d required 0", out_ch); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mr_valid: got %b required 1", out_valid); end
  endtask

  task automatic test_drain();
    in_valid = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if (sb_q.size() != 0) begin errors++; $display("FAIL drain_sb: got %0d pending required 0", sb_q.size()); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b required 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_static_sel();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_mode_switch();
    test_reset_midstream();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
